// File: rtl/addsub_arbiter.sv
// Two-requester arbiter and sequencer for one shared 4-bit add/subtract datapath.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module addsub_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       op1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] result,
  output logic       carry,
  output logic       overflow,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       op_q;
  logic       winner;
  logic [3:0] b_eff;
  logic [4:0] sum;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
  logic       last_grant;
`endif

  // On a tie the requester not served last wins, unless fixed priority is built in.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Subtraction is A + ~B + 1, so the carry-in is the opcode itself.
  always_comb begin
    b_eff = op_q ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_eff} + {4'b0000, op_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      op_q       <= 1'b0;
      grant_id   <= 1'b0;
      result     <= 4'd0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      busy <= (state_nxt != IDLE);
      ack0 <= (state_nxt == DONE) && !grant_id;
      ack1 <= (state_nxt == DONE) && grant_id;
      if (state == IDLE && state_nxt == EXEC) begin
        a_q        <= winner ? a1 : a0;
        b_q        <= winner ? b1 : b0;
        op_q       <= winner ? op1 : op0;
        grant_id   <= winner;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
        last_grant <= winner;
`endif
      end
      if (state == EXEC) begin
        result   <= sum[3:0];
        carry    <= sum[4];
        overflow <= (a_q[3] == b_eff[3]) && (sum[3] != a_q[3]);
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: directed scenarios plus random traffic against a
// transaction-level schedule model (grant edge, ack one edge later, next grant three edges later).
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic       ack0, ack1, carry, overflow, busy, grant_id;
  logic [3:0] result;

  int total = 0;
  int bad = 0;

  int       n = 0;
  int       free_at = 0;
  int       ack_at = -1;
  bit       last_m = 1'b1;
  bit       pend_id = 1'b0;
  bit       pend_c = 1'b0;
  bit       pend_o = 1'b0;
  bit [3:0] pend_res = 4'd0;
  bit       m_gid = 1'b0;
  bit       m_c = 1'b0;
  bit       m_o = 1'b0;
  bit [3:0] m_res = 4'd0;

  always #5 clk = ~clk;

  addsub_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .ack0(ack0), .ack1(ack1), .result(result), .carry(carry),
    .overflow(overflow), .busy(busy), .grant_id(grant_id)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    free_at = 0;
    ack_at  = -1;
    last_m  = 1'b1;
    m_gid   = 1'b0;
    m_res   = 4'd0;
    m_c     = 1'b0;
    m_o     = 1'b0;
  endtask

  // Advance one clock, update the reference from the inputs seen at that edge, compare all outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (n >= free_at && (req0 || req1)) begin
      bit w;
      bit opv;
      int av, bv, uu, sa, sb, ss;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
      if (req0 && req1) w = 1'b0;
`else
      if (req0 && req1) w = !last_m;
`endif
      else w = !req0;
      av  = w ? int'(a1) : int'(a0);
      bv  = w ? int'(b1) : int'(b0);
      opv = w ? op1 : op0;
      uu  = opv ? av - bv : av + bv;
      pend_res = 4'(uu & 15);
      pend_c   = opv ? (av >= bv) : (uu > 15);
      sa = (av > 7) ? av - 16 : av;
      sb = (bv > 7) ? bv - 16 : bv;
      ss = opv ? sa - sb : sa + sb;
      pend_o  = (ss > 7) || (ss < -8);
      pend_id = w;
      m_gid   = w;
      last_m  = w;
      ack_at  = n + 1;
      free_at = n + 3;
    end
    if (n == ack_at) begin
      m_res = pend_res;
      m_c   = pend_c;
      m_o   = pend_o;
    end
    checkOutput("ack0", ack0, 8'((n == ack_at) && !pend_id));
    checkOutput("ack1", ack1, 8'((n == ack_at) && pend_id));
    checkOutput("busy", busy, 8'(n < free_at - 1));
    checkOutput("grant_id", grant_id, 8'(m_gid));
    checkOutput("result", result, 8'(m_res));
    checkOutput("carry", carry, 8'(m_c));
    checkOutput("overflow", overflow, 8'(m_o));
  endtask

  // Issue one operation on an idle block and check its ack against hand-computed values.
  task automatic applyStimulus(input bit id, input logic [3:0] a, input logic [3:0] b,
                               input bit op, input logic [3:0] er, input bit ec,
                               input bit eo, input bit drop);
    int lat;
    bit got;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      tick();
      lat++;
      if (id ? ack1 : ack0) got = 1'b1;
    end
    checkOutput("ack_seen", 8'(got), 8'd1);
    checkOutput("latency", 8'(lat), 8'd2);
    checkOutput("op_result", result, 8'(er));
    checkOutput("op_carry", carry, 8'(ec));
    checkOutput("op_overflow", overflow, 8'(eo));
    checkOutput("op_grant", grant_id, 8'(id));
    if (drop) begin
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
    end
  endtask

  initial begin
    bit exp_ids [4];
    bit ids [4];
    int at [4];
    int cnt;

    // Reset with both requests active: everything stays cleared.
    req0 = 1'b1; a0 = 4'd6; b0 = 4'd2; op0 = 1'b0;
    req1 = 1'b1; a1 = 4'd3; b1 = 4'd9; op1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack0", ack0, 8'd0);
    checkOutput("rst_ack1", ack1, 8'd0);
    checkOutput("rst_result", result, 8'd0);
    checkOutput("rst_carry", carry, 8'd0);
    checkOutput("rst_overflow", overflow, 8'd0);
    checkOutput("rst_busy", busy, 8'd0);
    checkOutput("rst_grant", grant_id, 8'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_noack", 8'(ack0 | ack1), 8'd0);
    end

    applyStimulus(1'b0, 4'd5, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 4'd0, 4'd1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
    tick();

    // Contention: both requesters held high for four operations.
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd3; op0 = 1'b1;
    req1 = 1'b1; a1 = 4'd8; b1 = 4'd8; op1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 4; i++) begin
      tick();
      if (ack0 || ack1) begin
        ids[cnt] = ack1;
        at[cnt]  = n;
        cnt++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("cont_count", 8'(cnt), 8'd4);
    for (int k = 0; k < cnt; k++) begin
      checkOutput("cont_id", 8'(ids[k]), 8'(exp_ids[k]));
      if (k > 0) checkOutput("cont_gap", 8'(at[k] - at[k-1]), 8'd3);
    end
    repeat (2) tick();

    // Back-to-back on requester 0: new operands in the cycle after ack.
    applyStimulus(1'b0, 4'd4, 4'd9, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd3, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset during EXEC.
    req0 = 1'b1; a0 = 4'd9; b0 = 4'd4; op0 = 1'b0;
    tick();
    checkOutput("mid_busy_before", busy, 8'd1);
    rst_n = 1'b0;
    #1;
    req0 = 1'b0;
    model_reset();
    checkOutput("mid_result", result, 8'd0);
    checkOutput("mid_busy", busy, 8'd0);
    checkOutput("mid_ack", 8'(ack0 | ack1), 8'd0);
    checkOutput("mid_grant", grant_id, 8'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_ack_held", 8'(ack0 | ack1), 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    applyStimulus(1'b0, 4'd9, 4'd4, 1'b0, 4'd13, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();

    // Random traffic obeying the handshake.
    for (int i = 0; i < 400; i++) begin
      tick();
      if (req0) begin
        if (ack0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else begin a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom); end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom);
      end else begin
        a0 = 4'($urandom);
      end
      if (req1) begin
        if (ack1) begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else begin a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom); end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom);
      end else begin
        b1 = 4'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
